// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Holds the receiver state encoding, the parity mode codes and the oversample ratio.
package uart_pkg;

  localparam int OVS = 16;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Mode 3 is reserved and behaves like PAR_NONE.
  function automatic logic has_parity(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through receive FIFO: the head word is visible on r_data while not empty.
// A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
module uart_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_q [2**AW];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // The extra pointer MSB distinguishes full from empty when the addresses match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    r_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= w_data;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver with 16x oversampling, optional parity, configurable stop length,
// an FWFT receive FIFO and sticky parity/frame/overrun error flags.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 4,
  parameter int DVSR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              rx,
  input  logic              rd_uart,
  input  logic              err_clr,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              rx_full,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam logic [3:0] S_MID       = 4'(OVS / 2 - 1);
  localparam logic [3:0] S_LAST      = 4'(OVS - 1);
  localparam logic [3:0] N_LAST      = 4'(DBIT - 1);
  localparam logic [5:0] STOP_SAMPLE = 6'(OVS - 1);
  localparam logic [5:0] STOP_LAST   = 6'(SB_TICK - 1);

  rx_state_e         state_q, state_d;
  logic [1:0]        rx_sync_q, rx_sync_d;
  logic              rx_s;
  logic [DVSR_W-1:0] dvsr_l_q, dvsr_l_d;
  logic [DVSR_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [1:0]        par_l_q, par_l_d;
  logic [3:0]        s_q, s_d;
  logic [3:0]        n_q, n_d;
  logic [5:0]        stop_cnt_q, stop_cnt_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic              par_pend_q, par_pend_d;
  logic              par_bad;
  logic              push_word, par_set, frame_set, overrun_set;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_err_q, overrun_err_d;

  // Synchroniser and free-running tick generator; the counter wraps if the divisor shrinks.
  always_comb begin
    rx_sync_d  = {rx_sync_q[0], rx};
    rx_s       = rx_sync_q[1];
    tick       = (tick_cnt_q == dvsr_l_q);
    tick_cnt_d = (tick_cnt_q >= dvsr_l_q) ? '0 : tick_cnt_q + DVSR_W'(1);
    par_bad    = (^shift_q) ^ rx_s ^ (par_l_q == PAR_ODD);
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    dvsr_l_d   = dvsr_l_q;
    par_l_d    = par_l_q;
    push_word  = 1'b0;
    par_set    = 1'b0;
    frame_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          s_d        = '0;
          dvsr_l_d   = dvsr;
          par_l_d    = parity_mode;
          par_pend_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d     = '0;
            n_d     = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d        = '0;
            stop_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = has_parity(par_l_q) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + 4'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d        = '0;
            stop_cnt_d = '0;
            par_pend_d = par_bad;
            state_d    = ST_STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      // Sample once mid stop bit, then run out the rest of a long stop before re-arming.
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_SAMPLE) begin
            if (rx_s) begin
              push_word  = 1'b1;
              par_set    = par_pend_q;
              stop_cnt_d = stop_cnt_q + 6'd1;
              if (STOP_LAST <= STOP_SAMPLE) begin
                state_d = ST_IDLE;
              end
            end else begin
              frame_set = 1'b1;
              state_d   = ST_BREAK;
            end
          end else if (stop_cnt_q >= STOP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 6'd1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An err_clr coinciding with a new error leaves the flag set.
  always_comb begin
    overrun_set   = push_word && rx_full && !rd_uart;
    parity_err_d  = (parity_err_q  && !err_clr) || par_set;
    frame_err_d   = (frame_err_q   && !err_clr) || frame_set;
    overrun_err_d = (overrun_err_q && !err_clr) || overrun_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rx_sync_q     <= 2'b11;
      dvsr_l_q      <= '0;
      tick_cnt_q    <= '0;
      par_l_q       <= PAR_NONE;
      s_q           <= '0;
      n_q           <= '0;
      stop_cnt_q    <= '0;
      shift_q       <= '0;
      par_pend_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_sync_q     <= rx_sync_d;
      dvsr_l_q      <= dvsr_l_d;
      tick_cnt_q    <= tick_cnt_d;
      par_l_q       <= par_l_d;
      s_q           <= s_d;
      n_q           <= n_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      par_pend_q    <= par_pend_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  uart_fifo #(
    .DW(DBIT),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_word),
    .pop   (rd_uart),
    .w_data(shift_q),
    .r_data(r_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign busy        = (state_q != ST_IDLE);
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a 4-deep FIFO: framing, parity, break,
// glitch rejection, FIFO full/overrun and mid-frame reset.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dvsr;
  logic [1:0]  parity_mode;
  logic        rx;
  logic        rd_uart;
  logic        err_clr;
  logic [7:0]  r_data;
  logic        rx_empty, rx_full, busy;
  logic        parity_err, frame_err, overrun_err;

  int n_checks = 0;
  int n_fail   = 0;
  int bit_clk  = 64;
  int k_meas   = 0;
  bit seen;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DBIT(8),
    .SB_TICK(16),
    .FIFO_AW(2),
    .DVSR_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dvsr       (dvsr),
    .parity_mode(parity_mode),
    .rx         (rx),
    .rd_uart    (rd_uart),
    .err_clr    (err_clr),
    .r_data     (r_data),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting on the current negedge; rx is left at the stop level.
  task automatic applyStimulus(input logic [7:0] data, input bit has_par,
                               input logic par_bit, input logic stop_bit);
    rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (bit_clk) @(negedge clk);
    end
    if (has_par) begin
      rx = par_bit;
      repeat (bit_clk) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bit_clk) @(negedge clk);
  endtask

  task automatic waitBits(input int nbits);
    repeat (nbits * bit_clk) @(negedge clk);
  endtask

  task automatic popWord();
    rd_uart = 1'b1;
    @(negedge clk);
    rd_uart = 1'b0;
  endtask

  task automatic clearErrors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    rx          = 1'b1;
    rd_uart     = 1'b0;
    err_clr     = 1'b0;
    dvsr        = 16'd3;
    parity_mode = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_r_data", 32'(r_data), 32'h0);
    checkOutput("rst_rx_empty", 32'(rx_empty), 32'd1);
    checkOutput("rst_rx_full", 32'(rx_full), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_parity_err", 32'(parity_err), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_overrun_err", 32'(overrun_err), 32'd0);
    reset = 1'b1;
    waitBits(1);

    $display("[TB] 8N1 0xA5 with divisor changed mid-frame");
    fork
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (2 * bit_clk) @(negedge clk);
        checkOutput("a5_busy_mid", 32'(busy), 32'd1);
        dvsr = 16'd9;
      end
    join
    dvsr = 16'd3;
    waitBits(1);
    checkOutput("a5_rx_empty", 32'(rx_empty), 32'd0);
    checkOutput("a5_r_data", 32'(r_data), 32'hA5);
    checkOutput("a5_parity_err", 32'(parity_err), 32'd0);
    checkOutput("a5_frame_err", 32'(frame_err), 32'd0);
    checkOutput("a5_overrun_err", 32'(overrun_err), 32'd0);
    checkOutput("a5_busy_end", 32'(busy), 32'd0);
    popWord();
    checkOutput("a5_popped_empty", 32'(rx_empty), 32'd1);

    $display("[TB] even parity mismatch, then odd parity match");
    parity_mode = 2'd1;
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
    waitBits(1);
    checkOutput("even_r_data", 32'(r_data), 32'h3C);
    checkOutput("even_parity_err", 32'(parity_err), 32'd1);
    checkOutput("even_frame_err", 32'(frame_err), 32'd0);
    clearErrors();
    checkOutput("even_parity_clr", 32'(parity_err), 32'd0);
    popWord();
    parity_mode = 2'd2;
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
    waitBits(1);
    checkOutput("odd_r_data", 32'(r_data), 32'h07);
    checkOutput("odd_parity_err", 32'(parity_err), 32'd0);
    popWord();

    $display("[TB] stop bit low followed by a held break");
    parity_mode = 2'd0;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
    waitBits(40);
    checkOutput("brk_busy", 32'(busy), 32'd1);
    checkOutput("brk_frame_err", 32'(frame_err), 32'd1);
    checkOutput("brk_rx_empty", 32'(rx_empty), 32'd1);
    rx = 1'b1;
    waitBits(2);
    checkOutput("brk_busy_released", 32'(busy), 32'd0);
    checkOutput("brk_still_empty", 32'(rx_empty), 32'd1);
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b1);
    waitBits(2);
    checkOutput("brk_next_r_data", 32'(r_data), 32'h81);
    popWord();
    checkOutput("brk_exactly_one", 32'(rx_empty), 32'd1);
    clearErrors();
    checkOutput("brk_frame_clr", 32'(frame_err), 32'd0);

    $display("[TB] six-clock glitch on idle line");
    rx = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("glitch_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    waitBits(2);
    checkOutput("glitch_idle", 32'(busy), 32'd0);
    checkOutput("glitch_rx_empty", 32'(rx_empty), 32'd1);
    checkOutput("glitch_frame_err", 32'(frame_err), 32'd0);
    checkOutput("glitch_parity_err", 32'(parity_err), 32'd0);
    checkOutput("glitch_overrun_err", 32'(overrun_err), 32'd0);

    $display("[TB] divisor 0 with reserved parity mode");
    dvsr        = 16'd0;
    bit_clk     = 16;
    parity_mode = 2'd3;
    applyStimulus(8'h3E, 1'b0, 1'b0, 1'b1);
    waitBits(2);
    checkOutput("fast_r_data", 32'(r_data), 32'h3E);
    checkOutput("fast_parity_err", 32'(parity_err), 32'd0);
    popWord();
    dvsr        = 16'd3;
    bit_clk     = 64;
    parity_mode = 2'd0;

    $display("[TB] five frames into a four-deep FIFO without reads");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b0, 1'b1);
      waitBits(2);
    end
    checkOutput("ovr_rx_full", 32'(rx_full), 32'd1);
    checkOutput("ovr_overrun_err", 32'(overrun_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovr_word%0d", i), 32'(r_data), 32'(i));
      popWord();
    end
    checkOutput("ovr_drained", 32'(rx_empty), 32'd1);
    clearErrors();
    checkOutput("ovr_clr", 32'(overrun_err), 32'd0);

    $display("[TB] five frames with a read in the fifth push cycle");
    for (int i = 0; i < 5; i++) begin
      fork
        applyStimulus(8'(i), 1'b0, 1'b0, 1'b1);
        begin
          if (i == 4) begin
            if (k_meas > 1) begin
              repeat (k_meas - 1) @(negedge clk);
              rd_uart = 1'b1;
              @(negedge clk);
              rd_uart = 1'b0;
            end
          end else if (i == 3) begin
            seen   = 1'b0;
            k_meas = 0;
            for (int c = 1; c <= 20 * bit_clk && k_meas == 0; c++) begin
              @(negedge clk);
              if (busy) seen = 1'b1;
              else if (seen) k_meas = c;
            end
            checkOutput("push_cycle_found", 32'(k_meas != 0), 32'd1);
          end
        end
      join
      waitBits(2);
    end
    checkOutput("pp_rx_full", 32'(rx_full), 32'd1);
    checkOutput("pp_overrun_err", 32'(overrun_err), 32'd0);
    checkOutput("pp_head", 32'(r_data), 32'd1);
    popWord();
    checkOutput("pp_second", 32'(r_data), 32'd2);

    $display("[TB] reset mid-DATA, then a clean frame");
    rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    rx = 1'b0;
    repeat (bit_clk) @(negedge clk);
    rx = 1'b1;
    repeat (bit_clk / 2) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
    checkOutput("mid_rst_rx_full", 32'(rx_full), 32'd0);
    checkOutput("mid_rst_r_data", 32'(r_data), 32'h0);
    reset = 1'b1;
    waitBits(1);
    applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1);
    waitBits(2);
    checkOutput("post_r_data", 32'(r_data), 32'hC3);
    checkOutput("post_frame_err", 32'(frame_err), 32'd0);
    checkOutput("post_parity_err", 32'(parity_err), 32'd0);
    checkOutput("post_busy", 32'(busy), 32'd0);
    popWord();
    checkOutput("post_empty", 32'(rx_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
